// File: rtl/serial_host_pkg.sv
// serial_host_pkg
// Shared types and constants for the UART word-protocol host master.
//   cmd_e              : command codes carried in the low bits of the command word
//   state_e            : master FSM states
//   PING_VALUE_DEFAULT : word the responder returns to a ping
//   BYTES_PER_WORD     : bytes per protocol word, sent MSB first
package serial_host_pkg;

  typedef enum logic [2:0] {
    CMD_WRITE  = 3'd1,
    CMD_READ   = 3'd2,
    CMD_RUN    = 3'd3,
    CMD_CYCLES = 3'd4,
    CMD_MEMOPS = 3'd5,
    CMD_PING   = 3'd6
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    SEND_CMD,
    SEND_DATA,
    RECV_DATA,
    FINISH
  } state_e;

  localparam logic [31:0] PING_VALUE_DEFAULT = 32'd123456789;
  localparam int          BYTES_PER_WORD     = 4;

endpackage

// File: rtl/serial_word_shifter.sv
// serial_word_shifter
// Word <-> byte conversion for the UART word protocol.
//   clock, reset_n         : clock, asynchronous active-low reset
//   load, loadWord         : load a 32-bit word for transmission (taken only when txEmpty)
//   txEmpty                : no bytes of the current word left to launch
//   txLastLaunch           : the final byte of the current word is launching this cycle
//   txByte, txStart        : byte and one-cycle launch pulse to the UART transmitter
//   txReady                : transmitter idle
//   rxEnable               : assemble received bytes into words; when low bytes are dropped
//   rxByte, rxAvail        : received byte and its pending flag
//   rxClear                : acknowledge, same cycle the byte is taken
//   rxWord, rxWordValid    : assembled word, valid for one cycle after its 4th byte
module serial_word_shifter
  import serial_host_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] loadWord,
  output logic        txEmpty,
  output logic        txLastLaunch,
  output logic [7:0]  txByte,
  output logic        txStart,
  input  logic        txReady,
  input  logic        rxEnable,
  input  logic [7:0]  rxByte,
  input  logic        rxAvail,
  output logic        rxClear,
  output logic [31:0] rxWord,
  output logic        rxWordValid
);

  localparam logic [2:0] TX_FULL = 3'(BYTES_PER_WORD);
  localparam logic [1:0] RX_LAST = 2'(BYTES_PER_WORD - 1);

  logic [31:0] txShift;
  logic [2:0]  txCount;
  logic        txGuard;
  logic        launch;
  logic [23:0] rxShift;
  logic [1:0]  rxIdx;

  // The guard blocks a launch in the cycle after the previous one so the
  // transmitter has time to drop txReady.
  assign launch       = (txCount != 3'd0) && txReady && !txGuard;
  assign txStart      = launch;
  assign txByte       = txShift[31:24];
  assign txEmpty      = (txCount == 3'd0);
  assign txLastLaunch = launch && (txCount == 3'd1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      txShift <= '0;
      txCount <= '0;
      txGuard <= 1'b0;
    end else begin
      txGuard <= launch;
      if (launch) begin
        txShift <= {txShift[23:0], 8'h00};
        txCount <= txCount - 3'd1;
      end else if (load && txEmpty) begin
        txShift <= loadWord;
        txCount <= TX_FULL;
      end
    end
  end

  // Every pending byte is acknowledged; outside of word reception it is dropped.
  assign rxClear = rxAvail;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rxShift     <= '0;
      rxIdx       <= '0;
      rxWord      <= '0;
      rxWordValid <= 1'b0;
    end else begin
      rxWordValid <= 1'b0;
      if (!rxEnable) begin
        rxIdx <= '0;
      end else if (rxAvail) begin
        if (rxIdx == RX_LAST) begin
          rxWord      <= {rxShift, rxByte};
          rxWordValid <= 1'b1;
          rxIdx       <= '0;
        end else begin
          rxShift <= {rxShift[15:0], rxByte};
          rxIdx   <= rxIdx + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/serial_host_master.sv
// serial_host_master
// Host-side initiator for the UART word protocol: sends a command word, then
// streams bulk-write words or collects response words.
//   clock, reset_n                : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_code  : command request handshake
//   wr_data/wr_valid/wr_ready     : bulk-write word stream (cmd 1)
//   rd_data/rd_valid/rd_first     : received words; rd_first marks word 0 of a cmd 2 dump
//   done                          : one-cycle completion pulse
//   error                         : sticky timeout / ping-mismatch flag
//   tx_byte/tx_start/tx_ready     : UART transmitter side
//   rx_byte/rx_avail/rx_clear     : UART receiver side
module serial_host_master
  import serial_host_pkg::*;
#(
  parameter int          XFER_WORDS = 10001,
  parameter int          RX_TIMEOUT = 2000000,
  parameter logic [31:0] PING_VALUE = PING_VALUE_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_code,
  input  logic [31:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        rd_first,
  output logic        done,
  output logic        error,
  output logic [7:0]  tx_byte,
  output logic        tx_start,
  input  logic        tx_ready,
  input  logic [7:0]  rx_byte,
  input  logic        rx_avail,
  output logic        rx_clear
);

  localparam int                   TIMEOUT_W     = $clog2(RX_TIMEOUT + 1);
  localparam logic [16:0]          XFER_LAST     = 17'(XFER_WORDS);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LIMIT = TIMEOUT_W'(RX_TIMEOUT);

  state_e               state, stateNext;
  logic [2:0]           cmdReg, cmdNext;
  logic [16:0]          wordCnt, wordCntNext;
  logic [TIMEOUT_W-1:0] timeoutCnt, timeoutNext;
  logic                 errorReg, errorNext;

  logic        shLoad;
  logic [31:0] shWord;
  logic        txEmpty;
  logic        txLastLaunch;
  logic        rxEnable;
  logic [31:0] rxWord;
  logic        rxWordValid;
  logic [16:0] recvWords;

  serial_word_shifter shifter (
    .clock        (clock),
    .reset_n      (reset_n),
    .load         (shLoad),
    .loadWord     (shWord),
    .txEmpty      (txEmpty),
    .txLastLaunch (txLastLaunch),
    .txByte       (tx_byte),
    .txStart      (tx_start),
    .txReady      (tx_ready),
    .rxEnable     (rxEnable),
    .rxByte       (rx_byte),
    .rxAvail      (rx_avail),
    .rxClear      (rx_clear),
    .rxWord       (rxWord),
    .rxWordValid  (rxWordValid)
  );

  assign rxEnable  = (state == RECV_DATA);
  assign recvWords = (cmdReg == CMD_READ) ? XFER_LAST : 17'd1;
  assign cmd_ready = (state == IDLE);
  assign done      = (state == FINISH);
  assign error     = errorReg;
  assign rd_data   = rxWord;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cmdReg     <= '0;
      wordCnt    <= '0;
      timeoutCnt <= '0;
      errorReg   <= 1'b0;
    end else begin
      state      <= stateNext;
      cmdReg     <= cmdNext;
      wordCnt    <= wordCntNext;
      timeoutCnt <= timeoutNext;
      errorReg   <= errorNext;
    end
  end

  always_comb begin
    stateNext   = state;
    cmdNext     = cmdReg;
    wordCntNext = wordCnt;
    timeoutNext = '0;
    errorNext   = errorReg;
    shLoad      = 1'b0;
    shWord      = {29'b0, cmdReg};
    wr_ready    = 1'b0;
    rd_valid    = 1'b0;
    rd_first    = 1'b0;

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          // The command word is loaded into the shifter on acceptance.
          cmdNext     = cmd_code;
          errorNext   = 1'b0;
          wordCntNext = '0;
          shLoad      = 1'b1;
          shWord      = {29'b0, cmd_code};
          stateNext   = SEND_CMD;
        end
      end

      SEND_CMD: begin
        if (txLastLaunch) begin
          case (cmdReg)
            CMD_WRITE:                                     stateNext = SEND_DATA;
            CMD_READ, CMD_CYCLES, CMD_MEMOPS, CMD_PING:    stateNext = RECV_DATA;
            default:                                       stateNext = FINISH;
          endcase
        end
      end

      SEND_DATA: begin
        if (txEmpty && wr_valid && (wordCnt < XFER_LAST)) begin
          wr_ready    = 1'b1;
          shLoad      = 1'b1;
          shWord      = wr_data;
          wordCntNext = wordCnt + 17'd1;
        end
        if (txLastLaunch && (wordCnt == XFER_LAST)) begin
          stateNext = FINISH;
        end
      end

      RECV_DATA: begin
        timeoutNext = rx_avail ? '0 : timeoutCnt + 1'b1;
        if (rxWordValid) begin
          rd_valid = 1'b1;
          rd_first = (wordCnt == 17'd0) && (cmdReg == CMD_READ);
          if ((cmdReg == CMD_PING) && (rxWord != PING_VALUE)) begin
            errorNext = 1'b1;
          end
          if (wordCnt < XFER_LAST) begin
            wordCntNext = wordCnt + 17'd1;
          end
          if ((wordCnt + 17'd1) == recvWords) begin
            stateNext = FINISH;
          end
        end else if (!rx_avail && ((timeoutCnt + 1'b1) == TIMEOUT_LIMIT)) begin
          // Any partial word is discarded when the shifter leaves reception.
          errorNext = 1'b1;
          stateNext = FINISH;
        end
      end

      FINISH: stateNext = IDLE;

      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: doc/serial_host_master.md
Name: serial_host_master

Overview:
- Host-side initiator for the board's UART word protocol, used for loading and dumping SRAM, running the CPU, and reading its cycle counters.
- Lets an on-chip agent (test sequencer, second board, soft-core loader) play the role the PC normally plays.
- Sits between a local request/stream interface and a byte-level UART port, and serializes/deserializes 32-bit words MSB-byte-first.

Parameters:
- XFER_WORDS, 10001: words per bulk write (cmd 1) or bulk read (cmd 2); matches responder address wrap.
- RX_TIMEOUT, 2000000: idle cycles allowed between received bytes before error.
- PING_VALUE, 32'd123456789: expected cmd 6 reply.

Ports:
- clock in 1: system clock
- reset_n in 1: asynchronous, active-low reset
- cmd_valid in 1: request strobe; accepted when cmd_ready=1
- cmd_ready out 1: master idle, able to accept a command
- cmd_code in 3: 1=write, 2=read, 3=run, 4=cycle count, 5=mem-op count, 6=ping
- wr_data in 32: bulk-write word
- wr_valid in 1: wr_data valid
- wr_ready out 1: wr_data consumed this cycle
- rd_data out 32: received word
- rd_valid out 1: one-cycle pulse per received word
- rd_first out 1: with rd_valid, marks first word of a cmd 2 dump (responder residue; software discards)
- done out 1: one-cycle pulse at command completion
- error out 1: sticky; set on timeout or ping mismatch, cleared by next accepted command
- tx_byte out 8: byte to UART transmitter
- tx_start out 1: one-cycle launch pulse
- tx_ready in 1: transmitter idle
- rx_byte in 8: received byte
- rx_avail in 1: byte pending (level)
- rx_clear out 1: one-cycle acknowledge, same cycle rx_byte captured

Behaviour:
- Reset: all outputs 0 except cmd_ready=1. FSM to IDLE. Counters and shifters cleared. Reset mid-transfer abandons it; no tx_start until next command.
- Byte rules:
  - tx_start only when tx_ready=1 and not in the cycle after a previous tx_start. One-cycle guard lets tx_ready fall.
  - Word sent as bytes [31:24],[23:16],[15:8],[7:0].
  - rx: when rx_avail=1, shift rx_byte in from LSB side and pulse rx_clear that cycle. The 4th byte completes a word.
- FSM states: IDLE, SEND_CMD, SEND_DATA, RECV_DATA, FINISH.
- IDLE: cmd_valid&cmd_ready latches cmd_code, clears error, and goes to SEND_CMD. Codes 0 and 7 are accepted but only the command word is sent, then FINISH.
- SEND_CMD: transmits the 32-bit word {29'b0,cmd_code}. Next state after the 4th byte launches:
  - cmd 1 → SEND_DATA
  - cmd 2 and 4–6 → RECV_DATA
  - cmd 3 → FINISH
- SEND_DATA:
  - When the shifter is empty and wr_valid=1: pulse wr_ready, load the word, and increment word_cnt.
  - Stall while wr_valid=0; no timeout on the local side.
  - After word XFER_WORDS's last byte launches → FINISH.
- RECV_DATA:
  - Expected word count is XFER_WORDS for cmd 2, otherwise 1.
  - On each completed word: rd_valid=1 one cycle later, with rd_data=word and rd_first=(word_cnt==0 && cmd==2).
  - cmd 6: if word!=PING_VALUE, set error.
  - Timeout counter resets on every rx byte. Reaching RX_TIMEOUT sets error and goes to FINISH; partial bytes are discarded.
- FINISH: done=1 for one cycle, then IDLE (cmd_ready=1 the following cycle).
- Stray rx bytes in IDLE/SEND_*: consumed (rx_clear) and dropped.
- Counters: word_cnt is 17 bits and saturates at XFER_WORDS. The timeout counter is wide enough for RX_TIMEOUT.

Decomposition:
- Package serial_host_pkg holds:
  - cmd_e enum (CMD_WRITE=1 … CMD_PING=6)
  - state_e enum
  - PING_VALUE default
  - BYTES_PER_WORD=4
- Sub-module serial_word_shifter: word↔byte serializer/deserializer with tx guard-cycle logic and rx byte index. The FSM stays in serial_host_master.

Test Plan:
- Ping: cmd 6. The model transmits bytes 07 5B CD 15. Expect tx bytes 00 00 00 06, rd_data=0x075BCD15, error=0, and done after rd_valid.
- Ping mismatch: model returns 0x00000000. Expect error=1 with done. The next cmd 4 clears error.
- Bulk write (XFER_WORDS=3): wr_data 0x11223344, 0xA5A5A5A5, 0x00000001. Expect tx stream 00000001 11223344 A5A5A5A5 00000001, exactly 3 wr_ready pulses, then done. Inject wr_valid gaps → stream order unchanged.
- Bulk read (XFER_WORDS=3): model returns 3 words. Expect 3 rd_valid pulses, rd_first only on the first. Toggle tx_ready slowly → no tx_start while tx_ready=0.
- Timeout (RX_TIMEOUT=50): cmd 4, model sends 2 bytes then stops. Expect error at cycle 50 after the last byte, done pulse, no rd_valid.
- Reset mid-SEND_DATA: assert reset_n=0 → tx_start=0 immediately and cmd_ready=1. A following ping completes normally.
